// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with prescaler, parallel load, terminal-count pulse and HEX digits.
// Define COUNTER_SATURATE_EN to clamp at 0/MAX instead of wrapping.
module counter_mod_n #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255,
    parameter int DIV   = 1,
    localparam int DIGITS = (WIDTH + 3) / 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [DIV_W-1:0]    div_cnt;
    logic [WIDTH-1:0]    step_count;
    logic                step_tc;
    logic [WIDTH-1:0]    load_clamped;
    logic [4*DIGITS-1:0] count_pad;

    // Active-low segments, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;

    // Next count and tc for a prescaler step; an out-of-range count recovers to 0.
    always_comb begin
        step_count = count;
        step_tc    = 1'b0;
        if (count > MAX_V) begin
            step_count = '0;
        end else if (up) begin
`ifdef COUNTER_SATURATE_EN
            if (count != MAX_V) begin
                step_count = count + ONE;
                step_tc    = (count == MAX_V - ONE);
            end
`else
            if (count == MAX_V) begin
                step_count = '0;
                step_tc    = 1'b1;
            end else begin
                step_count = count + ONE;
            end
`endif
        end else begin
`ifdef COUNTER_SATURATE_EN
            if (count != '0) begin
                step_count = count - ONE;
                step_tc    = (count == ONE);
            end
`else
            if (count == '0) begin
                step_count = MAX_V;
                step_tc    = 1'b1;
            end else begin
                step_count = count - ONE;
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            div_cnt <= '0;
            tc      <= 1'b0;
        end else if (load) begin
            count   <= load_clamped;
            div_cnt <= '0;
            tc      <= 1'b0;
        end else if (enable) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                count   <= step_count;
                tc      <= step_tc;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
                tc      <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    // Top digit sees zero-extended bits when WIDTH is not a multiple of 4.
    assign count_pad = (4*DIGITS)'(count);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign HEX[7*i +: 7] = hex7(count_pad[4*i +: 4]);
    end

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n: an 8-bit DIV=1 instance and a MAX=9, DIV=4 instance.
module tb_counter_mod_n;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_en, a_up, a_load;
    logic [7:0]  a_lv, a_count;
    logic        a_tc;
    logic [13:0] a_hex;

    logic        b_rst, b_en, b_up, b_load;
    logic [3:0]  b_lv, b_count;
    logic        b_tc;
    logic [6:0]  b_hex;

    int errors = 0;
    int checks = 0;

    counter_mod_n #(.WIDTH(8), .MAX(255), .DIV(1)) u_a (
        .clock(clk), .reset(a_rst), .enable(a_en), .up(a_up), .load(a_load),
        .load_value(a_lv), .count(a_count), .tc(a_tc), .HEX(a_hex)
    );

    counter_mod_n #(.WIDTH(4), .MAX(9), .DIV(4)) u_b (
        .clock(clk), .reset(b_rst), .enable(b_en), .up(b_up), .load(b_load),
        .load_value(b_lv), .count(b_count), .tc(b_tc), .HEX(b_hex)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int exp_c;
        a_rst = 1'b1; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_lv = '0;
        b_rst = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_lv = '0;
        tick(2);
        check("a_reset_count", a_count, 0);
        check("a_reset_tc", a_tc, 0);
        check("a_reset_hex", a_hex, 14'h2040);
        check("b_reset_count", b_count, 0);
        check("b_reset_hex", b_hex, 7'h40);

        // Instance A: 256 up-steps at DIV=1.
        a_rst = 1'b0;
        tick(1);
        check("a_idle_after_release", a_count, 0);
        a_en = 1'b1;
        for (int t = 1; t <= 256; t++) begin
            tick(1);
            exp_c = SAT ? ((t > 255) ? 255 : t) : (t % 256);
            check("a_up_count", a_count, exp_c);
            check("a_up_tc", a_tc, SAT ? (t == 255) : (t == 256));
            if (t == 90)  check("a_hex_5A", a_hex, 14'h0908);
            if (t == 255) check("a_hex_FF", a_hex, 14'h070E);
            if (t == 256) check("a_hex_wrap", a_hex, SAT ? 14'h070E : 14'h2040);
        end
        tick(1);
        check("a_after_wrap_count", a_count, SAT ? 255 : 1);
        check("a_after_wrap_tc", a_tc, 0);
        a_load = 1'b1; a_lv = 8'h3C;
        tick(1);
        a_load = 1'b0; a_en = 1'b0;
        check("a_load_count", a_count, 8'h3C);
        check("a_load_hex", a_hex, 14'h1846);
        tick(3);
        check("a_hold", a_count, 8'h3C);

        // Instance B: MAX=9, DIV=4 up-count.
        b_rst = 1'b0;
        b_en = 1'b1; b_up = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick(1);
            exp_c = SAT ? (((t / 4) > 9) ? 9 : (t / 4)) : ((t / 4) % 10);
            check("b_up_count", b_count, exp_c);
            check("b_up_tc", b_tc, SAT ? (t == 36) : (t == 40));
        end
        tick(1);
        check("b_tc_one_cycle", b_tc, 0);

        // Down from 0 wraps to MAX; then an oversize load clamps.
        b_load = 1'b1; b_lv = 4'd0;
        tick(1);
        b_load = 1'b0; b_up = 1'b0;
        check("b_load0", b_count, 0);
        tick(3);
        check("b_down_wait", b_count, 0);
        tick(1);
        check("b_down_wrap_count", b_count, SAT ? 0 : 9);
        check("b_down_wrap_tc", b_tc, SAT ? 0 : 1);
        b_load = 1'b1; b_lv = 4'd14;
        tick(1);
        b_load = 1'b0;
        check("b_clamp_count", b_count, 9);
        check("b_clamp_tc", b_tc, 0);
        check("b_clamp_hex", b_hex, 7'h10);

        // Dropping enable for 3 clocks delays the step by 3 clocks.
        tick(3);
        check("b_stall_pre", b_count, 9);
        b_en = 1'b0;
        tick(3);
        check("b_stall_hold", b_count, 9);
        b_en = 1'b1;
        tick(1);
        check("b_stall_step", b_count, 8);

        // Load with enable at div_cnt=DIV-1: load wins, prescaler restarts.
        tick(3);
        check("b_pre_load", b_count, 8);
        b_load = 1'b1; b_lv = 4'd5;
        tick(1);
        b_load = 1'b0; b_up = 1'b1;
        check("b_load_wins", b_count, 5);
        check("b_load_hex", b_hex, 7'h12);
        tick(3);
        check("b_restart_wait", b_count, 5);
        tick(1);
        check("b_restart_step", b_count, 6);

        // Asynchronous reset between edges at count=7, mid-period.
        b_load = 1'b1; b_lv = 4'd7;
        tick(1);
        b_load = 1'b0;
        tick(2);
        check("b_pre_reset", b_count, 7);
        #2 b_rst = 1'b1;
        #1;
        check("b_async_count", b_count, 0);
        check("b_async_tc", b_tc, 0);
        #1 b_rst = 1'b0;
        tick(1);
        check("b_no_step_after_release", b_count, 0);
        tick(2);
        check("b_release_wait", b_count, 0);
        tick(1);
        check("b_release_step", b_count, 1);

        // Bound behaviour up from 8 and down from 1.
        b_load = 1'b1; b_lv = 4'd8; b_up = 1'b1;
        tick(1);
        b_load = 1'b0;
        tick(4);
        check("b_bound_up_count", b_count, 9);
        check("b_bound_up_tc", b_tc, SAT ? 1 : 0);
        tick(4);
        check("b_beyond_up_count", b_count, SAT ? 9 : 0);
        check("b_beyond_up_tc", b_tc, SAT ? 0 : 1);
        b_load = 1'b1; b_lv = 4'd1; b_up = 1'b0;
        tick(1);
        b_load = 1'b0;
        tick(4);
        check("b_bound_dn_count", b_count, 0);
        check("b_bound_dn_tc", b_tc, SAT ? 1 : 0);
        tick(4);
        check("b_beyond_dn_count", b_count, SAT ? 0 : 9);
        check("b_beyond_dn_tc", b_tc, SAT ? 0 : 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
